// File: rtl/expr_eval_pkg.sv
// Shared definitions for the expression evaluator: FSM state encoding,
// ASCII constants and the character classifier used by the control path.
package expr_eval_pkg;

    // One-hot control states.
    typedef enum logic [3:0] {
        ST_OPND = 4'b0001,  // expecting a digit
        ST_OPTR = 4'b0010,  // expecting an operator
        ST_ERR  = 4'b0100,  // draining a broken expression
        ST_DONE = 4'b1000   // holding the result for the consumer
    } state_e;

    localparam logic [7:0] ASCII_ZERO = 8'h30;
    localparam logic [7:0] ASCII_NINE = 8'h39;
    localparam logic [7:0] ASCII_PLUS = 8'h2B;
    localparam logic [7:0] ASCII_STAR = 8'h2A;

    typedef enum logic [1:0] {
        CC_DIGIT,
        CC_PLUS,
        CC_STAR,
        CC_ILLEGAL
    } char_class_e;

    // Map an ASCII code onto one of the four character classes.
    function automatic char_class_e classify(input logic [7:0] ch);
        char_class_e cls;
        if (ch >= ASCII_ZERO && ch <= ASCII_NINE) begin
            cls = CC_DIGIT;
        end else if (ch == ASCII_PLUS) begin
            cls = CC_PLUS;
        end else if (ch == ASCII_STAR) begin
            cls = CC_STAR;
        end else begin
            cls = CC_ILLEGAL;
        end
        return cls;
    endfunction

    // Numeric value of a digit character; only meaningful for CC_DIGIT.
    function automatic logic [3:0] digit_value(input logic [7:0] ch);
        logic [7:0] offset;
        offset = ch - ASCII_ZERO;
        return offset[3:0];
    endfunction

endpackage

// File: rtl/expr_eval_acc.sv
// Arithmetic datapath: sum accumulator S, term accumulator T, the pending
// STAR flag, sticky overflow and the registered result value.
module expr_eval_acc
    import expr_eval_pkg::*;
#(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         clear_i,     // result consumed: start a fresh expression
    input  logic         digit_i,     // legal digit accepted
    input  logic         plus_i,      // PLUS accepted
    input  logic         star_i,      // STAR accepted
    input  logic         finish_i,    // legal final digit: latch S+T
    input  logic         abort_i,     // erroneous end: latch zero result
    input  logic [3:0]   digit_val_i,
    output logic [W-1:0] res_data_o,
    output logic         res_ovf_o
);

    logic [W-1:0] s_q, s_d;
    logic [W-1:0] t_q, t_d;
    logic         star_q, star_d;
    logic         ovf_q, ovf_d;
    logic [W-1:0] res_q, res_d;
    logic         rovf_q, rovf_d;

    logic [W+3:0] prod;
    logic [W-1:0] t_new;
    logic         t_carry;
    logic [W:0]   sum_plus;
    logic [W:0]   sum_end;

    // The product is kept W+4 bits wide so any carry out of W bits is visible.
    assign prod     = {4'b0000, t_q} * {{W{1'b0}}, digit_val_i};
    assign t_new    = star_q ? prod[W-1:0] : {{(W-4){1'b0}}, digit_val_i};
    assign t_carry  = star_q && (prod[W+3:W] != 4'b0000);
    assign sum_plus = {1'b0, s_q} + {1'b0, t_q};
    // The closing sum must use the term already updated by the final digit.
    assign sum_end  = {1'b0, s_q} + {1'b0, t_new};

    // Next-state computation for the accumulators and the result register.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        s_d    = s_q;
        t_d    = t_q;
        star_d = star_q;
        ovf_d  = ovf_q;
        res_d  = res_q;
        rovf_d = rovf_q;
        if (clear_i) begin
            s_d    = '0;
            t_d    = '0;
            star_d = 1'b0;
            ovf_d  = 1'b0;
            res_d  = '0;
            rovf_d = 1'b0;
        end else begin
            if (digit_i) begin
                t_d   = t_new;
                ovf_d = ovf_q | t_carry;
            end
            if (plus_i) begin
                s_d    = sum_plus[W-1:0];
                ovf_d  = ovf_q | sum_plus[W];
                star_d = 1'b0;
            end
            if (star_i) begin
                star_d = 1'b1;
            end
            if (finish_i) begin
                res_d  = sum_end[W-1:0];
                rovf_d = ovf_q | t_carry | sum_end[W];
            end
            if (abort_i) begin
                res_d  = '0;
                rovf_d = 1'b0;
            end
        end
    end

    // Accumulator and result registers with asynchronous clear.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            s_q    <= '0;
            t_q    <= '0;
            star_q <= 1'b0;
            ovf_q  <= 1'b0;
            res_q  <= '0;
            rovf_q <= 1'b0;
        end else begin
            s_q    <= s_d;
            t_q    <= t_d;
            star_q <= star_d;
            ovf_q  <= ovf_d;
            res_q  <= res_d;
            rovf_q <= rovf_d;
        end
    end

    assign res_data_o = res_q;
    assign res_ovf_o  = rovf_q;

endmodule

// File: rtl/expr_eval.sv
// Streaming ASCII expression evaluator: single-digit operands, '+' and '*'
// with the usual precedence. Control FSM, handshakes, error flag and beat
// counter live here; arithmetic lives in expr_eval_acc.
module expr_eval
    import expr_eval_pkg::*;
#(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         in_valid,
    input  logic [7:0]   in_data,
    input  logic         in_last,
    output logic         in_ready,
    output logic         res_valid,
    input  logic         res_ready,
    output logic [W-1:0] res_data,
    output logic         res_err,
    output logic         res_ovf,
    output logic [7:0]   res_len
);

    state_e      state_q, state_d;
    char_class_e cls;
    logic [3:0]  dval;
    logic        fire;

    logic        digit_en;
    logic        plus_en;
    logic        star_en;
    logic        finish_en;
    logic        abort_en;
    logic        clear_en;

    logic        err_q, err_d;
    logic [7:0]  len_q, len_d;

    assign cls       = classify(in_data);
    assign dval      = digit_value(in_data);
    assign in_ready  = (state_q != ST_DONE);
    assign res_valid = (state_q == ST_DONE);
    assign fire      = in_valid && in_ready;

    // Next-state and datapath strobes for the parser FSM.
    always_comb begin
        state_d   = state_q;
        digit_en  = 1'b0;
        plus_en   = 1'b0;
        star_en   = 1'b0;
        finish_en = 1'b0;
        abort_en  = 1'b0;
        clear_en  = 1'b0;
        case (state_q)
            ST_OPND: begin
                if (fire) begin
                    if (cls == CC_DIGIT) begin
                        state_d  = ST_OPTR;
                        digit_en = 1'b1;
                    end else begin
                        state_d = ST_ERR;
                    end
                end
            end
            ST_OPTR: begin
                if (fire) begin
                    if (cls == CC_PLUS) begin
                        state_d = ST_OPND;
                        plus_en = 1'b1;
                    end else if (cls == CC_STAR) begin
                        state_d = ST_OPND;
                        star_en = 1'b1;
                    end else begin
                        state_d = ST_ERR;
                    end
                end
            end
            ST_ERR: begin
                // Discard beats until the terminating one arrives.
            end
            ST_DONE: begin
                if (res_ready) begin
                    state_d  = ST_OPND;
                    clear_en = 1'b1;
                end
            end
            default: begin
                state_d = ST_OPND;
            end
        endcase
        // The last beat always ends the expression; only a digit arriving
        // while a digit is expected closes it cleanly.
        if (fire && in_last) begin
            state_d = ST_DONE;
            if (state_q == ST_OPND && cls == CC_DIGIT) begin
                finish_en = 1'b1;
            end else begin
                abort_en = 1'b1;
            end
        end
    end

    // Error flag and saturating beat counter for the current expression.
    always_comb begin
        err_d = err_q;
        len_d = len_q;
        if (clear_en) begin
            err_d = 1'b0;
            len_d = '0;
        end else begin
            if (fire && len_q != 8'hFF) begin
                len_d = len_q + 8'd1;
            end
            if (abort_en) begin
                err_d = 1'b1;
            end
        end
    end

    // Control registers with asynchronous clear.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q <= ST_OPND;
            err_q   <= 1'b0;
            len_q   <= '0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
            len_q   <= len_d;
        end
    end

    expr_eval_acc #(
        .W (W)
    ) u_acc (
        .clk         (clk),
        .clr         (clr),
        .clear_i     (clear_en),
        .digit_i     (digit_en),
        .plus_i      (plus_en),
        .star_i      (star_en),
        .finish_i    (finish_en),
        .abort_i     (abort_en),
        .digit_val_i (dval),
        .res_data_o  (res_data),
        .res_ovf_o   (res_ovf)
    );

    assign res_err = err_q;
    assign res_len = len_q;

endmodule

// File: tb/tb_expr_eval.sv
// Self-checking bench for expr_eval: directed scenarios plus random
// expressions scored against a term-based arithmetic reference model.
module tb_expr_eval;

    localparam int W = 16;
    localparam longint LIMIT = 64'd1 << W;

    typedef logic [7:0] ch_t;

    logic         clk = 1'b0;
    logic         clr;
    logic         in_valid;
    logic [7:0]   in_data;
    logic         in_last;
    logic         in_ready;
    logic         res_valid;
    logic         res_ready;
    logic [W-1:0] res_data;
    logic         res_err;
    logic         res_ovf;
    logic [7:0]   res_len;

    int  errors = 0;
    int  checks = 0;
    ch_t expr_q[$];

    expr_eval #(.W(W)) dut (
        .clk       (clk),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_err   (res_err),
        .res_ovf   (res_ovf),
        .res_len   (res_len)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic load(input string s);
        expr_q.delete();
        for (int i = 0; i < s.len(); i++) expr_q.push_back(ch_t'(s[i]));
    endtask

    // Reference: syntax check by position parity, then evaluate as a sum of
    // products of single digits, flagging any value that leaves W bits.
    task automatic model(output logic [W-1:0] v, output logic e, output logic o,
                         output logic [7:0] n);
        int     sz;
        bit     bad;
        bit     ov;
        longint terms[$];
        longint term;
        longint raw;
        longint sum;
        sz  = expr_q.size();
        bad = (sz % 2 == 0);
        for (int i = 0; i < sz; i++) begin
            bit is_dig;
            bit is_op;
            is_dig = (expr_q[i] >= 8'h30) && (expr_q[i] <= 8'h39);
            is_op  = (expr_q[i] == 8'h2B) || (expr_q[i] == 8'h2A);
            if ((i % 2 == 0) && !is_dig) bad = 1'b1;
            if ((i % 2 == 1) && !is_op)  bad = 1'b1;
        end
        n = (sz > 255) ? 8'd255 : 8'(sz);
        if (bad) begin
            v = '0;
            e = 1'b1;
            o = 1'b0;
        end else begin
            ov   = 1'b0;
            term = longint'(expr_q[0]) - 48;
            for (int i = 1; i < sz; i += 2) begin
                longint d;
                d = longint'(expr_q[i+1]) - 48;
                if (expr_q[i] == 8'h2A) begin
                    raw = term * d;
                    if (raw >= LIMIT) ov = 1'b1;
                    term = raw % LIMIT;
                end else begin
                    terms.push_back(term);
                    term = d;
                end
            end
            terms.push_back(term);
            sum = 0;
            foreach (terms[k]) begin
                raw = sum + terms[k];
                if (raw >= LIMIT) ov = 1'b1;
                sum = raw % LIMIT;
            end
            v = W'(sum);
            e = 1'b0;
            o = ov;
        end
    endtask

    // Offer one beat and hold it until it is accepted (bounded wait).
    task automatic send_beat(input ch_t c, input logic last);
        int n;
        in_valid = 1'b1;
        in_data  = c;
        in_last  = last;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            n++;
            @(negedge clk);
        end
        check("in_ready_wait", in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = 8'($urandom);
    endtask

    task automatic send_expr(input int max_gap);
        for (int i = 0; i < expr_q.size(); i++) begin
            repeat ($urandom_range(0, max_gap)) begin
                @(posedge clk);
                #1;
            end
            send_beat(expr_q[i], (i == expr_q.size() - 1));
        end
    endtask

    task automatic check_result(input string tag, input logic [W-1:0] v, input logic e,
                                input logic o, input logic [7:0] n);
        check({tag, ".valid"},    res_valid, 1);
        check({tag, ".in_ready"}, in_ready, 0);
        check({tag, ".data"},     res_data, v);
        check({tag, ".err"},      res_err, e);
        check({tag, ".ovf"},      res_ovf, o);
        check({tag, ".len"},      res_len, n);
    endtask

    task automatic handshake(input string tag, input logic [W-1:0] v);
        repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
        end
        check({tag, ".held_valid"}, res_valid, 1);
        check({tag, ".held_data"},  res_data, v);
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        res_ready = 1'b0;
        check({tag, ".released"}, res_valid, 0);
        check({tag, ".ready_back"}, in_ready, 1);
        check({tag, ".len_clear"}, res_len, 0);
    endtask

    task automatic run(input string tag, input logic [W-1:0] v, input logic e,
                       input logic o, input logic [7:0] n);
        send_expr(1);
        check_result(tag, v, e, o, n);
        handshake(tag, v);
    endtask

    task automatic run_model(input string tag);
        logic [W-1:0] v;
        logic         e;
        logic         o;
        logic [7:0]   n;
        model(v, e, o, n);
        run(tag, v, e, o, n);
    endtask

    task automatic gen_random();
        int len;
        len = 2 * $urandom_range(0, 6) + 1;
        if ($urandom_range(0, 7) == 0) len = len + 1;
        expr_q.delete();
        for (int i = 0; i < len; i++) begin
            if ($urandom_range(0, 19) == 0) begin
                expr_q.push_back(8'($urandom_range(0, 255)));
            end else if (i % 2 == 0) begin
                expr_q.push_back(8'(48 + $urandom_range(0, 9)));
            end else begin
                expr_q.push_back(($urandom_range(0, 2) == 0) ? 8'h2B : 8'h2A);
            end
        end
    endtask

    initial begin
        clr       = 1'b1;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        in_last   = 1'b0;
        res_ready = 1'b0;
        #12;
        check("rst.valid", res_valid, 0);
        check("rst.data",  res_data, 0);
        check("rst.err",   res_err, 0);
        check("rst.ovf",   res_ovf, 0);
        check("rst.len",   res_len, 0);
        check("rst.ready", in_ready, 1);
        clr = 1'b0;
        @(posedge clk);
        #1;

        // "2+3*4" with res_ready held high: result visible for one cycle only.
        load("2+3*4");
        res_ready = 1'b1;
        send_expr(0);
        check_result("prec", 16'd14, 1'b0, 1'b0, 8'd5);
        @(posedge clk);
        #1;
        check("prec.one_cycle", res_valid, 0);
        check("prec.ready_back", in_ready, 1);
        res_ready = 1'b0;

        load("*5");
        run("lead_star", 16'd0, 1'b1, 1'b0, 8'd2);
        load("4+");
        run("trail_plus", 16'd0, 1'b1, 1'b0, 8'd2);

        load("9*9*9*9*9");
        run("pow5", 16'd59049, 1'b0, 1'b0, 8'd9);
        load("9*9*9*9*9*9");
        run("pow6", 16'd7153, 1'b0, 1'b1, 8'd11);

        // Result held while the consumer stalls and a beat is being offered.
        load("1+2");
        send_expr(0);
        check_result("stall", 16'd3, 1'b0, 1'b0, 8'd3);
        in_valid = 1'b1;
        in_data  = 8'h39;
        in_last  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("stall.in_ready", in_ready, 0);
            check("stall.data", res_data, 3);
            check("stall.len", res_len, 3);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        handshake("stall", 16'd3);
        load("7");
        run("after_stall", 16'd7, 1'b0, 1'b0, 8'd1);

        // Asynchronous clear mid-expression.
        load("3+");
        send_expr(0);
        #2;
        clr = 1'b1;
        #1;
        check("clr_mid.valid", res_valid, 0);
        check("clr_mid.data",  res_data, 0);
        check("clr_mid.err",   res_err, 0);
        check("clr_mid.ovf",   res_ovf, 0);
        check("clr_mid.len",   res_len, 0);
        check("clr_mid.ready", in_ready, 1);
        #1;
        clr = 1'b0;
        @(posedge clk);
        #1;
        load("5");
        run("after_clr", 16'd5, 1'b0, 1'b0, 8'd1);

        // Asynchronous clear while a result is held.
        load("4*4");
        send_expr(0);
        check("clr_done.pre", res_valid, 1);
        #2;
        clr = 1'b1;
        #1;
        check("clr_done.valid", res_valid, 0);
        check("clr_done.data",  res_data, 0);
        #1;
        clr = 1'b0;
        @(posedge clk);
        #1;

        load("2a+1");
        run("illegal", 16'd0, 1'b1, 1'b0, 8'd4);
        load("8*2");
        run("after_illegal", 16'd16, 1'b0, 1'b0, 8'd3);

        load("1+2+3+4+5+6+7+8+9");
        run_model("sum_chain");

        // Beat counter saturation on a long drained expression.
        expr_q.delete();
        for (int i = 0; i < 300; i++) expr_q.push_back(8'h31);
        run("saturate", 16'd0, 1'b1, 1'b0, 8'd255);

        for (int r = 0; r < 40; r++) begin
            gen_random();
            run_model("rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/expr_eval.md
EXPR_EVAL -- requirements
Module: expr_eval

Interface
REQ-001 Parameter: W, 16, width of the result and of the internal accumulators (W >= 8).
REQ-002 clk  in  1  clock; all state changes on its rising edge.
REQ-003 clr  in  1  reset, asynchronous, active-high.
REQ-004 in_valid  in  1  character beat offered.
REQ-005 in_data  in  8  ASCII character.
REQ-006 in_last  in  1  beat is the final character of the expression.
REQ-007 in_ready  out  1  block accepts the beat this cycle.
REQ-008 res_valid  out  1  result available.
REQ-009 res_ready  in  1  consumer takes the result.
REQ-010 res_data  out  W  expression value, modulo 2^W.
REQ-011 res_err  out  1  syntax or character error in the expression.
REQ-012 res_ovf  out  1  an intermediate value exceeded 2^W-1.
REQ-013 res_len  out  8  accepted beats in the expression, saturating at 255.

Function
REQ-014 A beat transfers when in_valid && in_ready; in_data and in_last are ignored otherwise.
REQ-015 Character classes: digit 0x30-0x39 (value 0-9), PLUS 0x2B, STAR 0x2A; every other code is ILLEGAL.
REQ-016 The FSM has four states: OPND (expect digit), OPTR (expect operator), ERR (drain), DONE (hold result).
REQ-017 OPND: a digit moves to OPTR; PLUS, STAR or ILLEGAL moves to ERR.
REQ-018 OPTR: PLUS or STAR moves to OPND; a digit or ILLEGAL moves to ERR.
REQ-019 Any accepted beat with in_last moves to DONE. res_err=1 if that beat errored, or the state was ERR, or the beat was not a digit that legally ended the expression.
REQ-020 ERR: beats are accepted and discarded until a beat with in_last arrives.
REQ-021 Precedence: STAR binds tighter than PLUS; evaluation is left-to-right, using a sum accumulator S and a term accumulator T, both W bits.
REQ-022 Digit d: T <= T*d if the previous operator was STAR, else T <= d. PLUS: S <= S+T. End of expression: res_data <= S+T.
REQ-023 All arithmetic wraps modulo 2^W; res_ovf is sticky per expression and is set when any product or sum carries out of W bits.
REQ-024 On an error result, res_data=0 and res_ovf=0.
REQ-025 res_len counts every accepted beat of the expression, including the last beat and discarded beats.
REQ-026 in_ready=1 in OPND, OPTR and ERR; in_ready=0 in DONE.
REQ-027 res_valid=1 only in DONE, asserted the cycle after the in_last beat; res_data, res_err, res_ovf and res_len hold stable until res_ready.
REQ-028 When res_valid && res_ready: S, T, the counter and the flags clear, and the FSM moves to OPND. in_ready rises the following cycle; there is no same-cycle bypass.

Reset
REQ-029 clr forces, immediately and regardless of clk: state=OPND, S=T=0, in_ready=1 after release, res_valid=0, res_data=0, res_err=0, res_ovf=0, res_len=0.
REQ-030 clr asserted mid-expression or mid-DONE discards all partial state; no result is emitted for that expression.

Structure
REQ-031 A shared package holds the state encoding (one-hot, 4 bits), the ASCII constants for '0', '9', '+' and '*', and the character-class enumeration.
REQ-032 The datapath (S, T, multiply, add, overflow detection) is one sub-module, expr_eval_acc; the FSM and handshake logic stay in expr_eval.

Verification
REQ-033 Input "2+3*4", in_last on '4', res_ready=1 -> res_data=14, res_err=0, res_ovf=0, res_len=5, res_valid exactly one cycle.
REQ-034 Inputs "*5" (last on '5') and "4+" (last on '+') -> each gives res_err=1, res_data=0; res_len=2 for each.
REQ-035 W=16: "9*9*9*9*9" -> 59049, res_ovf=0; "9*9*9*9*9*9" -> 7153, res_ovf=1, res_err=0.
REQ-036 Input "1+2", then res_ready held low 5 cycles while in_valid=1 -> in_ready=0 and res_data=3 stable throughout; after the handshake, "7" -> res_data=7.
REQ-037 clr pulsed after "3+" (between clocks) -> all outputs 0 immediately; then "5" (last) -> res_data=5, res_len=1.
REQ-038 Input "2a+1" -> drains to the last beat, then res_err=1, res_len=4; the next expression "8*2" -> 16.
